rsa_keygen_arbiter: RTL and testbench
=====================================

RSA_KEYGEN_ARBITER -- requirements
Module: rsa_keygen_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width of p, q and e; results are 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 1024, maximum engine cycles counted in WAIT before abort; legal range 2..65535.
REQ-003 One clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  2  per-requester request strobe; bit i is requester i.
REQ-007 req_ready  output  2  one-hot acceptance; the request completes on req_valid[i] & req_ready[i].
REQ-008 req_p, req_q, req_e  input  2*WIDTH each  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 eng_start  output  1  single-cycle launch pulse to the shared private-key engine.
REQ-010 eng_p, eng_q, eng_e  output  WIDTH each  latched operands; stable from launch until the response is consumed.
REQ-011 eng_d, eng_n  input  2*WIDTH each  engine results; sampled only when eng_finish=1.
REQ-012 eng_finish  input  1  engine completion, valid only in WAIT.
REQ-013 rsp_valid  output  1  response held high until accepted.
REQ-014 rsp_ready  input  1  response consumer acceptance.
REQ-015 rsp_id  output  1  index of the served requester.
REQ-016 rsp_d, rsp_n  output  2*WIDTH each  private exponent and modulus; zero when rsp_err!=0.
REQ-017 rsp_err  output  2  00 ok, 01 engine timeout, 10 illegal operands.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 FSM states: IDLE, LAUNCH, WAIT, RESP; one request in flight at a time.
REQ-020 IDLE, arbitration: round-robin pointer ptr; ptr is granted if req_valid[ptr]=1, otherwise the other requester if valid.
REQ-021 req_ready is combinational, nonzero only in IDLE, and equals the one-hot grant.
REQ-022 On acceptance, latch the operands, rsp_id and legality.
REQ-023 On acceptance, set ptr to the inverse of the granted index.
REQ-024 On acceptance, go to LAUNCH if legal, else to RESP with rsp_err=10.
REQ-025 Operands are illegal if e==0, p<2 or q<2; an illegal request never asserts eng_start.
REQ-026 LAUNCH: eng_start=1 for exactly this cycle, timer cleared to 0, next state WAIT.
REQ-027 WAIT: timer increments each cycle.
REQ-028 WAIT: on eng_finish=1, latch rsp_d=eng_d, rsp_n=eng_n, rsp_err=00 and go to RESP.
REQ-029 WAIT: if eng_finish=0 and timer==TIMEOUT-1, set rsp_err=01, rsp_d=rsp_n=0 and go to RESP.
REQ-030 Finish and timeout in the same cycle: finish wins.
REQ-031 RESP: rsp_valid=1 with rsp_id, rsp_d, rsp_n and rsp_err held stable.
REQ-032 RESP: on rsp_ready=1, go to IDLE.
REQ-033 A new grant is possible in the cycle after the rsp handshake, never in the same cycle.
REQ-034 Latency, legal request accepted at cycle T: eng_start at T+1.
REQ-035 Latency, finish sampled at cycle F: rsp_valid from F+1.
REQ-036 Latency, illegal request accepted at T: rsp_valid at T+1.
REQ-037 eng_finish outside WAIT is ignored.
REQ-038 req_valid deasserting before a grant is legal and loses nothing.
REQ-039 Timer width is ceil(log2(TIMEOUT)) bits; it never wraps, because the timeout fires first.

Reset
REQ-040 rst=1 at any edge forces IDLE, ptr=0, timer=0, and all registered outputs (eng_start, eng_p/q/e, rsp_valid, rsp_id, rsp_d, rsp_n, rsp_err, busy) to 0.
REQ-041 rst=1 forces req_ready=0 in the same cycle.
REQ-042 Reset mid-operation abandons the in-flight request with no response; the engine is reset by its own reset.

Verification
REQ-043 Single request: req 0 with p=61, q=53, e=17; engine model finishes 10 cycles after eng_start -> eng_start exactly 1 cycle; rsp_valid with rsp_id=0, rsp_n=3233, rsp_d=2753, rsp_err=00.
REQ-044 Contention: req_valid=11 held continuously, with rsp_ready=1 -> grants alternate 0,1,0,1 starting from 0 after reset.
REQ-045 Illegal operands: req 1 with e=0 -> no eng_start; rsp_valid at T+1 with rsp_err=10, rsp_d=rsp_n=0.
REQ-046 Timeout: TIMEOUT=16, engine never finishes -> rsp_err=01 at 16 cycles after LAUNCH; eng_finish pulsed in the exact timeout cycle of a rerun -> rsp_err=00.
REQ-047 Backpressure: rsp_ready=0 for 5 cycles -> rsp outputs stable and req_ready=00 throughout; handshake then grant on the following cycle.
REQ-048 Reset mid-operation: rst in WAIT -> next cycle busy=0, rsp_valid=0; a later eng_finish is ignored.

Source files
------------

// File: rtl/rsa_keygen_arbiter_if.sv
// rtl/rsa_keygen_arbiter_if.sv - request, engine and response channels of the RSA key-generation arbiter
//
// Purpose: bundles every non-clock signal of rsa_keygen_arbiter.
//   req_*  : two-requester request channel (packed per-requester operands)
//   eng_*  : launch/complete channel to the shared private-key engine
//   rsp_*  : single response channel back to the consumer
//   busy   : arbiter not idle
// Modports: slave = arbiter view, master = environment view.
interface rsa_keygen_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_p;
  logic [2*WIDTH-1:0] req_q;
  logic [2*WIDTH-1:0] req_e;

  logic               eng_start;
  logic [WIDTH-1:0]   eng_p;
  logic [WIDTH-1:0]   eng_q;
  logic [WIDTH-1:0]   eng_e;
  logic [2*WIDTH-1:0] eng_d;
  logic [2*WIDTH-1:0] eng_n;
  logic               eng_finish;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_d;
  logic [2*WIDTH-1:0] rsp_n;
  logic [1:0]         rsp_err;

  logic               busy;

  modport slave (
    input  req_valid, req_p, req_q, req_e,
    input  eng_d, eng_n, eng_finish,
    input  rsp_ready,
    output req_ready,
    output eng_start, eng_p, eng_q, eng_e,
    output rsp_valid, rsp_id, rsp_d, rsp_n, rsp_err,
    output busy
  );

  modport master (
    output req_valid, req_p, req_q, req_e,
    output eng_d, eng_n, eng_finish,
    output rsp_ready,
    input  req_ready,
    input  eng_start, eng_p, eng_q, eng_e,
    input  rsp_valid, rsp_id, rsp_d, rsp_n, rsp_err,
    input  busy
  );
endinterface

// File: rtl/rsa_keygen_arbiter.sv
// rtl/rsa_keygen_arbiter.sv - two-requester round-robin front end for a shared RSA private-key engine
//
// Purpose: grants one of two requesters at a time, screens the operands,
// launches the engine, bounds its runtime with a timeout and holds the
// result until the consumer takes it.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : rsa_keygen_arbiter_if.slave
//         req_valid/req_ready/req_p/req_q/req_e  request channel
//         eng_start/eng_p/eng_q/eng_e            engine launch and operands
//         eng_finish/eng_d/eng_n                 engine completion and results
//         rsp_valid/rsp_ready/rsp_id/rsp_d/rsp_n/rsp_err  response channel
//         busy                                   state is not IDLE
module rsa_keygen_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  rsa_keygen_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  logic [1:0]         state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               eng_start_q, eng_start_d;
  logic [WIDTH-1:0]   eng_p_q, eng_p_d;
  logic [WIDTH-1:0]   eng_q_q, eng_q_d;
  logic [WIDTH-1:0]   eng_e_q, eng_e_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_d_q, rsp_d_d;
  logic [2*WIDTH-1:0] rsp_n_q, rsp_n_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [1:0]       grant;
  logic             gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_p, sel_q, sel_e;
  logic             legal;

  // Round-robin: the pointed-to requester wins if valid, otherwise the other one.
  always_comb begin
    grant = 2'b00;
    if (ptr_q) begin
      if (bus.req_valid[1])      grant = 2'b10;
      else if (bus.req_valid[0]) grant = 2'b01;
    end else begin
      if (bus.req_valid[0])      grant = 2'b01;
      else if (bus.req_valid[1]) grant = 2'b10;
    end
  end

  assign gnt_idx = grant[1];
  // Gated by rst so no handshake can complete while reset is asserted.
  assign accept  = (state_q == S_IDLE) && (grant != 2'b00) && !rst;

  assign sel_p = gnt_idx ? bus.req_p[2*WIDTH-1:WIDTH] : bus.req_p[WIDTH-1:0];
  assign sel_q = gnt_idx ? bus.req_q[2*WIDTH-1:WIDTH] : bus.req_q[WIDTH-1:0];
  assign sel_e = gnt_idx ? bus.req_e[2*WIDTH-1:WIDTH] : bus.req_e[WIDTH-1:0];

  assign legal = (sel_e != '0) && (sel_p > WIDTH'(1)) && (sel_q > WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    eng_start_d = 1'b0;
    eng_p_d     = eng_p_q;
    eng_q_d     = eng_q_q;
    eng_e_d     = eng_e_q;
    rsp_id_d    = rsp_id_q;
    rsp_d_d     = rsp_d_q;
    rsp_n_d     = rsp_n_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ptr_d    = ~gnt_idx;
          eng_p_d  = sel_p;
          eng_q_d  = sel_q;
          eng_e_d  = sel_e;
          rsp_id_d = gnt_idx;
          rsp_d_d  = '0;
          rsp_n_d  = '0;
          if (legal) begin
            state_d     = S_LAUNCH;
            eng_start_d = 1'b1;
            rsp_err_d   = ERR_OK;
          end else begin
            // Illegal operands bypass the engine entirely.
            state_d   = S_RESP;
            rsp_err_d = ERR_ILLEGAL;
          end
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Finish is checked first so it wins over a same-cycle timeout.
        if (bus.eng_finish) begin
          rsp_d_d   = bus.eng_d;
          rsp_n_d   = bus.eng_n;
          rsp_err_d = ERR_OK;
          state_d   = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_d_d   = '0;
          rsp_n_d   = '0;
          rsp_err_d = ERR_TIMEOUT;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      timer_q     <= '0;
      eng_start_q <= 1'b0;
      eng_p_q     <= '0;
      eng_q_q     <= '0;
      eng_e_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_d_q     <= '0;
      rsp_n_q     <= '0;
      rsp_err_q   <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      eng_start_q <= eng_start_d;
      eng_p_q     <= eng_p_d;
      eng_q_q     <= eng_q_d;
      eng_e_q     <= eng_e_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_d_q     <= rsp_d_d;
      rsp_n_q     <= rsp_n_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = accept ? grant : 2'b00;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_p     = eng_p_q;
  assign bus.eng_q     = eng_q_q;
  assign bus.eng_e     = eng_e_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_d     = rsp_d_q;
  assign bus.rsp_n     = rsp_n_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rsa_keygen_arbiter.sv
// tb/tb_rsa_keygen_arbiter.sv - self-checking bench for rsa_keygen_arbiter
`timescale 1ns/1ps
module tb_rsa_keygen_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_keygen_arbiter_if #(.WIDTH(WIDTH)) ifc ();

  rsa_keygen_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] d;
    logic [15:0] n;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Engine model: raises eng_finish eng_delay cycles after eng_start, n = p*q.
  int          eng_delay  = 10;
  int          eng_cnt    = 0;
  bit          eng_active = 1'b0;
  logic        eng_fin_m  = 1'b0;
  logic        kick_fin   = 1'b0;
  logic [15:0] eng_d_val  = 16'd0;
  logic [15:0] eng_n_m    = 16'd0;

  assign ifc.eng_finish = eng_fin_m | kick_fin;
  assign ifc.eng_d      = eng_d_val;
  assign ifc.eng_n      = eng_n_m;

  always @(negedge clk) begin
    if (rst) begin
      eng_active = 1'b0;
      eng_fin_m  = 1'b0;
      eng_cnt    = 0;
    end else if (ifc.eng_start) begin
      eng_active = 1'b1;
      eng_cnt    = 0;
      eng_fin_m  = 1'b0;
    end else if (eng_active) begin
      eng_cnt++;
      if (eng_cnt == eng_delay) begin
        eng_fin_m  = 1'b1;
        eng_n_m    = 16'(ifc.eng_p) * 16'(ifc.eng_q);
        eng_active = 1'b0;
      end
    end else begin
      eng_fin_m = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_valid = 2'b11;
    ifc.req_p = {8'd11, 8'd61}; ifc.req_q = {8'd13, 8'd53}; ifc.req_e = {8'd7, 8'd17};
    step(); step();
    n_cmp++; if (ifc.req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready actual=%b required=00", ifc.req_ready); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy actual=%b required=0", ifc.busy); end
    n_cmp++; if (ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid actual=%b required=0", ifc.rsp_valid); end
    n_cmp++; if (ifc.eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start actual=%b required=0", ifc.eng_start); end
    n_cmp++; if ({ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n} !== 35'd0) begin n_bad++; $display("FAIL reset_rsp_fields actual=%h required=0", {ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n}); end
    n_cmp++; if ({ifc.eng_p, ifc.eng_q, ifc.eng_e} !== 24'd0) begin n_bad++; $display("FAIL reset_eng_ops actual=%h required=0", {ifc.eng_p, ifc.eng_q, ifc.eng_e}); end
    ifc.req_valid = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int k;
    eng_delay = 10; eng_d_val = 16'd2753;
    ifc.req_p = {8'd0, 8'd61}; ifc.req_q = {8'd0, 8'd53}; ifc.req_e = {8'd0, 8'd17};
    ifc.req_valid = 2'b01;
    #1;
    n_cmp++; if (ifc.req_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant actual=%b required=01", ifc.req_ready); end
    sb.push_back('{id: 1'b0, d: 16'd2753, n: 16'd3233, err: 2'b00});
    step();
    ifc.req_valid = 2'b00;
    n_cmp++; if (ifc.eng_start !== 1'b1) begin n_bad++; $display("FAIL single_eng_start_t1 actual=%b required=1", ifc.eng_start); end
    n_cmp++; if ({ifc.eng_p, ifc.eng_q, ifc.eng_e} !== {8'd61, 8'd53, 8'd17}) begin n_bad++; $display("FAIL single_eng_ops actual=%h required=%h", {ifc.eng_p, ifc.eng_q, ifc.eng_e}, {8'd61, 8'd53, 8'd17}); end
    step();
    n_cmp++; if (ifc.eng_start !== 1'b0) begin n_bad++; $display("FAIL single_eng_start_len actual=%b required=0", ifc.eng_start); end
    k = 0;
    while (!ifc.rsp_valid && k < 40) begin step(); k++; end
    n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL single_rsp_latency actual=%0d required=10", k); end
    ex = sb.pop_front();
    n_cmp++; if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err} !== {1'b1, ex.id, ex.err}) begin n_bad++; $display("FAIL single_rsp_ctl actual=%b required=%b", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err}, {1'b1, ex.id, ex.err}); end
    n_cmp++; if ({ifc.rsp_d, ifc.rsp_n} !== {ex.d, ex.n}) begin n_bad++; $display("FAIL single_rsp_data actual=%0d/%0d required=%0d/%0d", ifc.rsp_d, ifc.rsp_n, ex.d, ex.n); end
    ifc.rsp_ready = 1'b1;
    step();
    ifc.rsp_ready = 1'b0;
    n_cmp++; if ({ifc.rsp_valid, ifc.busy} !== 2'b00) begin n_bad++; $display("FAIL single_after_hs actual=%b required=00", {ifc.rsp_valid, ifc.busy}); end
  endtask

  task automatic test_contention();
    int grants[$];
    int got;
    rst = 1'b1; step(); step(); rst = 1'b0;
    eng_delay = 3; eng_d_val = 16'd77;
    ifc.req_p = {8'd11, 8'd61}; ifc.req_q = {8'd13, 8'd53}; ifc.req_e = {8'd7, 8'd17};
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 1'b1;
    got = 0;
    #1;
    for (int c = 0; c < 200 && (grants.size() < 4 || got < 4); c++) begin
      if (grants.size() == 4) ifc.req_valid = 2'b00;
      #1;
      if (ifc.req_ready != 2'b00) begin
        n_cmp++; if (ifc.req_ready !== (grants.size() % 2 == 0 ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL contention_grant%0d actual=%b required=%b", grants.size(), ifc.req_ready, (grants.size() % 2 == 0 ? 2'b01 : 2'b10)); end
        n_cmp++; if (ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL contention_grant_during_rsp actual=%b required=0", ifc.rsp_valid); end
        grants.push_back(int'(ifc.req_ready[1]));
        if (ifc.req_ready[1]) sb.push_back('{id: 1'b1, d: 16'd77, n: 16'd143, err: 2'b00});
        else                  sb.push_back('{id: 1'b0, d: 16'd77, n: 16'd3233, err: 2'b00});
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        ex = sb.pop_front();
        n_cmp++; if ({ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n} !== {ex.id, ex.err, ex.d, ex.n}) begin n_bad++; $display("FAIL contention_rsp%0d actual=%h required=%h", got, {ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n}, {ex.id, ex.err, ex.d, ex.n}); end
        got++;
      end
      step();
    end
    n_cmp++; if (grants.size() !== 4 || got !== 4) begin n_bad++; $display("FAIL contention_count actual=%0d/%0d required=4/4", grants.size(), got); end
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    logic       ids[3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ps[3]  = '{8'd7, 8'd1, 8'd9};
    logic [7:0] qs[3]  = '{8'd5, 8'd5, 8'd1};
    logic [7:0] es[3]  = '{8'd0, 8'd3, 8'd3};
    eng_d_val = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      ifc.req_p = ids[i] ? {ps[i], 8'd99} : {8'd99, ps[i]};
      ifc.req_q = ids[i] ? {qs[i], 8'd97} : {8'd97, qs[i]};
      ifc.req_e = ids[i] ? {es[i], 8'd5}  : {8'd5, es[i]};
      ifc.req_valid = ids[i] ? 2'b10 : 2'b01;
      #1;
      n_cmp++; if (ifc.req_ready !== (ids[i] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL illegal%0d_grant actual=%b required=%b", i, ifc.req_ready, (ids[i] ? 2'b10 : 2'b01)); end
      sb.push_back('{id: ids[i], d: 16'd0, n: 16'd0, err: 2'b10});
      step();
      ifc.req_valid = 2'b00;
      n_cmp++; if ({ifc.rsp_valid, ifc.eng_start} !== 2'b10) begin n_bad++; $display("FAIL illegal%0d_t1 actual=rsp_valid,eng_start=%b required=10", i, {ifc.rsp_valid, ifc.eng_start}); end
      ex = sb.pop_front();
      n_cmp++; if ({ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n} !== {ex.id, ex.err, ex.d, ex.n}) begin n_bad++; $display("FAIL illegal%0d_rsp actual=%h required=%h", i, {ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n}, {ex.id, ex.err, ex.d, ex.n}); end
      step();
      n_cmp++; if (ifc.eng_start !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_no_start actual=%b required=0", i, ifc.eng_start); end
      ifc.rsp_ready = 1'b1;
      step();
      ifc.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int k;
    int delays[2]  = '{1000, 16};
    for (int r = 0; r < 2; r++) begin
      eng_delay = delays[r]; eng_d_val = 16'd29;
      ifc.req_p = {8'd0, 8'd5}; ifc.req_q = {8'd0, 8'd7}; ifc.req_e = {8'd0, 8'd5};
      ifc.req_valid = 2'b01;
      if (r == 0) sb.push_back('{id: 1'b0, d: 16'd0,  n: 16'd0,  err: 2'b01});
      else        sb.push_back('{id: 1'b0, d: 16'd29, n: 16'd35, err: 2'b00});
      step();
      ifc.req_valid = 2'b00;
      n_cmp++; if (ifc.eng_start !== 1'b1) begin n_bad++; $display("FAIL timeout%0d_eng_start actual=%b required=1", r, ifc.eng_start); end
      k = 0;
      while (!ifc.rsp_valid && k < 40) begin step(); k++; end
      // Decision in the 16th cycle after LAUNCH, response visible the cycle after.
      n_cmp++; if (k !== 17) begin n_bad++; $display("FAIL timeout%0d_latency actual=%0d required=17", r, k); end
      ex = sb.pop_front();
      n_cmp++; if ({ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n} !== {ex.id, ex.err, ex.d, ex.n}) begin n_bad++; $display("FAIL timeout%0d_rsp actual=%h required=%h", r, {ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n}, {ex.id, ex.err, ex.d, ex.n}); end
      ifc.rsp_ready = 1'b1;
      step();
      ifc.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int k;
    eng_delay = 3; eng_d_val = 16'd2753;
    ifc.req_p = {8'd11, 8'd61}; ifc.req_q = {8'd13, 8'd53}; ifc.req_e = {8'd7, 8'd17};
    ifc.req_valid = 2'b01;
    sb.push_back('{id: 1'b0, d: 16'd2753, n: 16'd3233, err: 2'b00});
    step();
    ifc.req_valid = 2'b00;
    k = 0;
    while (!ifc.rsp_valid && k < 40) begin step(); k++; end
    ifc.req_valid = 2'b11;
    #1;
    ex = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if ({ifc.rsp_valid, ifc.req_ready, ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n} !== {1'b1, 2'b00, ex.id, ex.err, ex.d, ex.n}) begin n_bad++; $display("FAIL backpressure_hold%0d actual=%h required=%h", c, {ifc.rsp_valid, ifc.req_ready, ifc.rsp_id, ifc.rsp_err, ifc.rsp_d, ifc.rsp_n}, {1'b1, 2'b00, ex.id, ex.err, ex.d, ex.n}); end
      step();
    end
    ifc.rsp_ready = 1'b1;
    #1;
    n_cmp++; if (ifc.req_ready !== 2'b00) begin n_bad++; $display("FAIL backpressure_hs_cycle_grant actual=%b required=00", ifc.req_ready); end
    step();
    ifc.rsp_ready = 1'b0;
    #1;
    n_cmp++; if ({ifc.rsp_valid, ifc.req_ready} !== 3'b010) begin n_bad++; $display("FAIL backpressure_next_grant actual=%b required=010", {ifc.rsp_valid, ifc.req_ready}); end
    ifc.req_valid = 2'b00;
    step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL backpressure_withdraw_busy actual=%b required=0", ifc.busy); end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    eng_delay = 10; eng_d_val = 16'd2753;
    ifc.req_p = {8'd0, 8'd61}; ifc.req_q = {8'd0, 8'd53}; ifc.req_e = {8'd0, 8'd17};
    ifc.req_valid = 2'b01;
    step();
    ifc.req_valid = 2'b00;
    n_cmp++; if (ifc.eng_start !== 1'b1) begin n_bad++; $display("FAIL resetmid_eng_start actual=%b required=1", ifc.eng_start); end
    step(); step(); step();
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL resetmid_busy_in_wait actual=%b required=1", ifc.busy); end
    rst = 1'b1;
    step();
    n_cmp++; if ({ifc.busy, ifc.rsp_valid, ifc.eng_start} !== 3'b000) begin n_bad++; $display("FAIL resetmid_after_rst actual=%b required=000", {ifc.busy, ifc.rsp_valid, ifc.eng_start}); end
    step();
    rst = 1'b0;
    step();
    kick_fin = 1'b1;
    step();
    kick_fin = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (ifc.rsp_valid || ifc.busy) saw_rsp = 1'b1;
      step();
    end
    n_cmp++; if (saw_rsp !== 1'b0) begin n_bad++; $display("FAIL resetmid_late_finish actual=%b required=0", saw_rsp); end
  endtask

  initial begin
    ifc.req_valid = 2'b00;
    ifc.req_p     = '0;
    ifc.req_q     = '0;
    ifc.req_e     = '0;
    ifc.rsp_ready = 1'b0;

    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_reset_mid();

    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
